// File: rtl/aes_ti_pkg.sv
// Shared definitions for the threshold-implementation AES key schedule: FSM encoding,
// Rcon constants and the GF(2^8) doubling used to step Rcon.
package aes_ti_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SUB, UPD, FIN} stateT;

  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  localparam logic [7:0] AES_RCON_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: doubles in GF(2^8) on Advance, reloads to 01 on Clear.
module aes_rcon_gen
  import aes_ti_pkg::*;
(
  input  logic       ClkxCI,
  input  logic       RstxBI,
  input  logic       AdvancexSI,
  input  logic       ClearxSI,
  output logic [7:0] RconxDO
);

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI)         RconxDO <= AES_RCON_INIT;
    else if (ClearxSI)   RconxDO <= AES_RCON_INIT;
    else if (AdvancexSI) RconxDO <= xtime(RconxDO);
  end

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// Byte-serial AES-128 key expansion for one share: loads the cipher key into the external
// key register file and derives NROUNDS round keys through a shared external S-box.
module aes_key_expand_ctrl
  import aes_ti_pkg::*;
#(
  parameter int SBOX_LAT = 1,
  parameter int NROUNDS  = 10
) (
  input  logic       ClkxCI,
  input  logic       RstxBI,
  input  logic       StartxSI,
  input  logic [7:0] KeyBytexDI,
  input  logic [7:0] KeyOutxDI,
  input  logic [7:0] KeyToSboxxDI,
  input  logic [7:0] SboxOutxDI,
  output logic [7:0] KeyInxDO,
  output logic       KeySchedulexSO,
  output logic       ForthCyclexSO,
  output logic       SboxReqxSO,
  output logic       RoundKeyValidxSO,
  output logic [3:0] RoundxDO,
  output logic       DonexSO
);

  stateT           StatexDP, StatexDN;
  logic [3:0]      CntxDP;
  logic [3:0]      RoundxDP;
  logic            DrainxSP;
  logic [7:0]      RconxD;
  logic [3:0][7:0] DlyxDP, BufxDP;
  logic [SBOX_LAT:1] VldQxDP;
  logic [SBOX_LAT:0] vld_pipe;
  logic [1:0]      BufIdx;
  logic [7:0]      NewByte;
  logic            LastCnt, LastRound;

  assign LastCnt   = (CntxDP == 4'd15);
  assign LastRound = (RoundxDP == 4'(NROUNDS - 1));

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      StatexDP <= IDLE;
      CntxDP   <= 4'd0;
    end else begin
      StatexDP <= StatexDN;
      CntxDP   <= (StatexDN != StatexDP) ? 4'd0 : CntxDP + 4'd1;
    end
  end

  always_comb begin
    StatexDN = StatexDP;
    case (StatexDP)
      IDLE:    if (StartxSI) StatexDN = LOAD;
      LOAD:    if (LastCnt) StatexDN = SUB;
      SUB:     if (LastCnt) StatexDN = UPD;
      UPD:     if (LastCnt) StatexDN = LastRound ? FIN : SUB;
      FIN:     StatexDN = IDLE;
      default: StatexDN = IDLE;
    endcase
  end

  // S-box requests travel down vld_pipe; the tap SBOX_LAT stages later marks the result byte.
  assign vld_pipe = {VldQxDP, SboxReqxSO};
  assign BufIdx   = 2'(CntxDP - 4'(SBOX_LAT));

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      RoundxDP <= 4'd0;
      DrainxSP <= 1'b0;
      DlyxDP   <= '0;
      BufxDP   <= '0;
      VldQxDP  <= '0;
    end else begin
      VldQxDP <= vld_pipe[SBOX_LAT-1:0];
      if (vld_pipe[SBOX_LAT]) BufxDP[BufIdx] <= SboxOutxDI;
      if (StatexDP == UPD) DlyxDP <= {DlyxDP[2:0], NewByte};
      if (StatexDP == IDLE && StatexDN == LOAD) RoundxDP <= 4'd0;
      else if (StatexDP == UPD && LastCnt)      RoundxDP <= RoundxDP + 4'd1;
      if (StatexDP == FIN)                                DrainxSP <= 1'b1;
      else if (StatexDN != IDLE || CntxDP == 4'd14)       DrainxSP <= 1'b0;
    end
  end

  aes_rcon_gen u_rcon (
    .ClkxCI     (ClkxCI),
    .RstxBI     (RstxBI),
    .AdvancexSI (StatexDP == UPD && LastCnt),
    .ClearxSI   (StatexDP == IDLE),
    .RconxDO    (RconxD)
  );

  always_comb begin
    NewByte = KeyOutxDI ^ DlyxDP[3];
    if (CntxDP < 4'd4)  NewByte = KeyOutxDI ^ BufxDP[CntxDP[1:0]];
    if (CntxDP == 4'd0) NewByte = NewByte ^ RconxD;
  end

  // The final key leaves K00 over FIN plus 15 drain cycles in IDLE, all in rotate mode
  // so the register file keeps it intact while it is read out.
  always_comb begin
    KeyInxDO         = 8'h00;
    KeySchedulexSO   = 1'b0;
    ForthCyclexSO    = 1'b0;
    SboxReqxSO       = 1'b0;
    RoundKeyValidxSO = 1'b0;
    DonexSO          = 1'b0;
    case (StatexDP)
      IDLE: begin
        KeySchedulexSO   = DrainxSP;
        RoundKeyValidxSO = DrainxSP;
      end
      LOAD: KeyInxDO = KeyBytexDI;
      SUB: begin
        KeySchedulexSO   = 1'b1;
        RoundKeyValidxSO = 1'b1;
        SboxReqxSO       = (CntxDP < 4'd4);
        ForthCyclexSO    = (CntxDP == 4'd3);
      end
      UPD: KeyInxDO = NewByte;
      FIN: begin
        DonexSO          = 1'b1;
        KeySchedulexSO   = 1'b1;
        RoundKeyValidxSO = 1'b1;
      end
      default: ;
    endcase
  end

  assign RoundxDO = RoundxDP;

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Bench for aes_key_expand_ctrl: two instances (S-box latency 1 and 12) each driving a
// behavioural key register file and S-box, checked against a FIPS-197 key-schedule timeline.
module tb_aes_key_expand_ctrl;

  localparam int NR = 10;

  logic       ClkxC = 1'b0;
  logic       RstxB, StartxS;
  logic [7:0] KeyBytexD;
  logic [7:0] KeyOut[2], KeyToSbox[2], SboxOut[2], KeyIn[2];
  logic       Ks[2], Fc[2], Req[2], Rkv[2], Done[2];
  logic [3:0] Round[2];

  logic [7:0] regs[2][16];
  logic [7:0] pipe[2][12];
  logic [7:0] smpKin[2], smpTo[2];
  logic       smpKs[2];
  logic [7:0] sbox[256];
  logic [7:0] keyB[16];
  logic [7:0] rk[11][16];
  logic [7:0] kstream[2][11][16];
  logic [7:0] rconTab[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int t = 0;
  int checks = 0;
  int errs = 0;

  always #5 ClkxC = ~ClkxC;

  aes_key_expand_ctrl #(.SBOX_LAT(1), .NROUNDS(NR)) u0 (
    .ClkxCI(ClkxC), .RstxBI(RstxB), .StartxSI(StartxS), .KeyBytexDI(KeyBytexD),
    .KeyOutxDI(KeyOut[0]), .KeyToSboxxDI(KeyToSbox[0]), .SboxOutxDI(SboxOut[0]),
    .KeyInxDO(KeyIn[0]), .KeySchedulexSO(Ks[0]), .ForthCyclexSO(Fc[0]), .SboxReqxSO(Req[0]),
    .RoundKeyValidxSO(Rkv[0]), .RoundxDO(Round[0]), .DonexSO(Done[0]));

  aes_key_expand_ctrl #(.SBOX_LAT(12), .NROUNDS(NR)) u1 (
    .ClkxCI(ClkxC), .RstxBI(RstxB), .StartxSI(StartxS), .KeyBytexDI(KeyBytexD),
    .KeyOutxDI(KeyOut[1]), .KeyToSboxxDI(KeyToSbox[1]), .SboxOutxDI(SboxOut[1]),
    .KeyInxDO(KeyIn[1]), .KeySchedulexSO(Ks[1]), .ForthCyclexSO(Fc[1]), .SboxReqxSO(Req[1]),
    .RoundKeyValidxSO(Rkv[1]), .RoundxDO(Round[1]), .DonexSO(Done[1]));

  // Key register file: K00 = regs[0], K33 = regs[15]; S-box path taps K13, or K12 on the fourth byte.
  assign KeyOut[0]    = regs[0][0];
  assign KeyOut[1]    = regs[1][0];
  assign KeyToSbox[0] = Fc[0] ? regs[0][9] : regs[0][13];
  assign KeyToSbox[1] = Fc[1] ? regs[1][9] : regs[1][13];
  assign SboxOut[0]   = pipe[0][0];
  assign SboxOut[1]   = pipe[1][11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s u%0d t=%0d got=%0h want=%0h", nm, inst, t, act, exp);
    end
  endtask

  task automatic expandKey();
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = {keyB[4*i], keyB[4*i+1], keyB[4*i+2], keyB[4*i+3]};
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= NR; r++)
      for (int b = 0; b < 16; b++) rk[r][b] = w[4*r + b/4][31 - 8*(b%4) -: 8];
  endtask

  function automatic logic [127:0] packRk(input int r);
    logic [127:0] v;
    v = '0;
    for (int b = 0; b < 16; b++) v = {v[119:0], rk[r][b]};
    return v;
  endfunction

  function automatic logic [127:0] packKs(input int i, input int r);
    logic [127:0] v;
    v = '0;
    for (int b = 0; b < 16; b++) v = {v[119:0], kstream[i][r][b]};
    return v;
  endfunction

  task automatic setKey(input logic [127:0] k);
    for (int b = 0; b < 16; b++) keyB[b] = k[127 - 8*b -: 8];
  endtask

  // Run timeline: t=1 is the first LOAD cycle after Start is sampled; FIN at t=337.
  always @(posedge ClkxC or negedge RstxB) begin
    if (!RstxB) t = 0;
    else if ((t == 0 || t > 337) && StartxS) begin t = 1; expandKey(); end
    else if (t != 0) t = t + 1;
  end

  always @(negedge ClkxC) begin
    for (int i = 0; i < 2; i++) begin
      smpKin[i] = KeyIn[i];
      smpKs[i]  = Ks[i];
      smpTo[i]  = KeyToSbox[i];
    end
  end

  always @(posedge ClkxC) begin
    logic [7:0] tmp;
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int j = 11; j > 0; j--) pipe[i][j] = pipe[i][j-1];
      pipe[i][0] = sbox[smpTo[i]];
      tmp = smpKs[i] ? regs[i][0] : smpKin[i];
      for (int j = 0; j < 15; j++) regs[i][j] = regs[i][j+1];
      regs[i][15] = tmp;
    end
  end

  always @(negedge ClkxC) begin : cmp
    logic ks, rkv, req, fc, dn, kinChk, rconChk;
    logic [7:0] kin;
    logic [3:0] rnd;
    int kr, kb, k, p;
    ks = 0; rkv = 0; req = 0; fc = 0; dn = 0; kinChk = 0; rconChk = 0;
    kin = 8'h00; rnd = 4'd0; kr = 0; kb = 0; k = 0;
    if (t == 0) kinChk = 1;
    else if (t <= 16) begin kinChk = 1; kin = keyB[t-1]; end
    else if (t <= 16 + 32*NR) begin
      k = t - 17; p = k % 32; rnd = 4'(k / 32);
      if (p < 16) begin ks = 1; rkv = 1; req = (p < 4); fc = (p == 3); kr = k / 32; kb = p; end
      else begin kinChk = 1; kin = rk[k/32 + 1][p-16]; rconChk = (p == 16); end
    end else begin
      rnd = 4'(NR);
      dn = (t == 337);
      if (t <= 352) begin ks = 1; rkv = 1; kr = NR; kb = t - 337; end
      if (t > 337) kinChk = 1;
    end
    for (int i = 0; i < 2; i++) begin
      chk("keysched", i, Ks[i], ks);
      chk("rkvalid", i, Rkv[i], rkv);
      chk("sboxreq", i, Req[i], req);
      chk("forth", i, Fc[i], fc);
      chk("done", i, Done[i], dn);
      chk("round", i, Round[i], rnd);
      if (kinChk) chk("keyin", i, KeyIn[i], kin);
      if (rkv) begin
        chk("k00", i, KeyOut[i], rk[kr][kb]);
        kstream[i][kr][kb] = KeyOut[i];
      end
    end
    if (rconChk) begin
      chk("rcon", 0, u0.RconxD, rconTab[k/32]);
      chk("rcon", 1, u1.RconxD, rconTab[k/32]);
    end
  end

  task automatic startRun(input logic extraStarts);
    for (int i = 0; i < 2; i++)
      for (int r = 0; r <= NR; r++)
        for (int b = 0; b < 16; b++) kstream[i][r][b] = 8'h00;
    @(posedge ClkxC); #1 StartxS = 1'b1;
    @(posedge ClkxC); #1 StartxS = 1'b0; KeyBytexD = keyB[0];
    for (int i = 1; i < 16; i++) begin
      @(posedge ClkxC); #1 KeyBytexD = keyB[i];
      StartxS = (extraStarts && i == 4);
    end
    @(posedge ClkxC); #1 KeyBytexD = 8'ha5; StartxS = 1'b0;
    if (extraStarts) begin
      repeat (3) @(posedge ClkxC);
      #1 StartxS = 1'b1;
      @(posedge ClkxC); #1 StartxS = 1'b0;
    end
  endtask

  task automatic waitDone(input string nm);
    int n;
    n = 0;
    while (!Done[0] && n < 400) begin @(negedge ClkxC); n++; end
    chk({nm, "_done_cycle"}, 0, t, 337);
    chk({nm, "_done_lat12"}, 1, Done[1], 1'b1);
    repeat (20) @(posedge ClkxC);
    #1;
  endtask

  initial begin
    logic [7:0] inv;
    int n;
    RstxB = 1'b0; StartxS = 1'b0; KeyBytexD = 8'h00;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    chk("model_sbox00", 0, sbox[8'h00], 8'h63);
    chk("model_sbox53", 0, sbox[8'h53], 8'hed);
    setKey(128'h00000000000000000000000000000000);
    expandKey();
    chk("model_zero_r1", 0, packRk(1), 128'h62636363626363636263636362636363);
    setKey(128'h2b7e151628aed2a6abf7158809cf4f3c);
    expandKey();
    chk("model_fips_r10", 0, packRk(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    repeat (2) @(posedge ClkxC);
    #1;
    for (int i = 0; i < 2; i++)
      chk("reset_outs", i, {KeyIn[i], Ks[i], Fc[i], Req[i], Rkv[i], Round[i], Done[i]}, '0);
    RstxB = 1'b1;
    repeat (3) @(posedge ClkxC);

    // FIPS-197 key with stray Start pulses during LOAD and SUB
    setKey(128'h2b7e151628aed2a6abf7158809cf4f3c);
    startRun(1'b1);
    waitDone("fips");
    for (int i = 0; i < 2; i++) begin
      chk("fips_r0_stream", i, packKs(i, 0), 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("fips_r10_stream", i, packKs(i, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    end

    setKey(128'h0);
    startRun(1'b0);
    waitDone("zero");
    for (int i = 0; i < 2; i++)
      chk("zero_r1_stream", i, packKs(i, 1), 128'h62636363626363636263636362636363);

    // Abort in UPD of round 3 at cnt 7 (t=136)
    setKey(128'h2b7e151628aed2a6abf7158809cf4f3c);
    startRun(1'b0);
    n = 0;
    while (t != 136 && n < 400) begin @(posedge ClkxC); #1; n++; end
    chk("abort_reached", 0, t, 136);
    RstxB = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      chk("abort_outs", i, {KeyIn[i], Ks[i], Fc[i], Req[i], Rkv[i], Round[i], Done[i]}, '0);
    repeat (2) @(posedge ClkxC);
    #1 RstxB = 1'b1;

    startRun(1'b0);
    waitDone("rerun");
    for (int i = 0; i < 2; i++)
      chk("rerun_r10_stream", i, packKs(i, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    repeat (5) @(posedge ClkxC);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
